// File: rtl/life_step_engine_pkg.sv
// Shared definitions for the row-serial Game of Life engine: grid geometry,
// generation counter width, FSM state encoding and the cell index helper.
package life_step_engine_pkg;

    localparam int GRID_W = 64;
    localparam int GRID_H = 48;
    localparam int GEN_W  = 16;
    localparam int CELLS  = GRID_W * GRID_H;
    localparam int ROW_W  = 6;
    localparam int IDX_W  = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_COMMIT  = 2'd2
    } fsm_e;

    // Flat bit position of cell (x,y); callers guarantee the coordinates are in range
    function automatic logic [IDX_W-1:0] cell_idx(input logic [7:0] x, input logic [7:0] y);
        return IDX_W'(y) * IDX_W'(GRID_W) + IDX_W'(x);
    endfunction

endpackage

// File: rtl/life_step_engine_row_calc.sv
// life_row_calc: combinational next-generation logic for one 64-cell row,
// given the rows above and below. Horizontal edges wrap when LIFE_TORUS_EN
// is defined; otherwise columns -1 and 64 read as dead.
module life_row_calc
    import life_step_engine_pkg::*;
(
    input  logic [GRID_W-1:0] row_up,
    input  logic [GRID_W-1:0] row_cur,
    input  logic [GRID_W-1:0] row_dn,
    output logic [GRID_W-1:0] row_next
);

    // Rows padded by one column each side: ext[0] is column -1, ext[GRID_W+1] is column GRID_W
    logic [GRID_W+1:0] ext_up;
    logic [GRID_W+1:0] ext_cur;
    logic [GRID_W+1:0] ext_dn;
    logic [3:0]        cnt;

`ifdef LIFE_TORUS_EN
    assign ext_up  = {row_up[0],  row_up,  row_up[GRID_W-1]};
    assign ext_cur = {row_cur[0], row_cur, row_cur[GRID_W-1]};
    assign ext_dn  = {row_dn[0],  row_dn,  row_dn[GRID_W-1]};
`else
    assign ext_up  = {1'b0, row_up,  1'b0};
    assign ext_cur = {1'b0, row_cur, 1'b0};
    assign ext_dn  = {1'b0, row_dn,  1'b0};
`endif

    // Sum of the eight neighbours of one cell (0..8)
    function automatic logic [3:0] nbr_cnt(input logic [2:0] up, input logic [2:0] cur,
                                           input logic [2:0] dn);
        return 4'(up[0]) + 4'(up[1]) + 4'(up[2]) + 4'(cur[0]) + 4'(cur[2])
             + 4'(dn[0]) + 4'(dn[1]) + 4'(dn[2]);
    endfunction

    // Apply survive-on-2-or-3 / born-on-3 to every column of the row
    always_comb begin
        row_next = '0;
        cnt      = '0;
        for (int x = 0; x < GRID_W; x++) begin
            cnt = nbr_cnt(ext_up[x +: 3], ext_cur[x +: 3], ext_dn[x +: 3]);
            row_next[x] = (cnt == 4'd3) || (row_cur[x] && (cnt == 4'd2));
        end
    end

endmodule

// File: rtl/life_step_engine.sv
// life_step_engine: owns the 64x48 cell array. A step computes one row per
// cycle into a shadow buffer (48 cycles) and then commits the whole frame in
// one cycle, so the display never sees a partial generation. Also services
// single-cell writes while idle. Vertical wrap follows LIFE_TORUS_EN.
module life_step_engine
    import life_step_engine_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             step_req,
    input  logic             freeze,
    input  logic             wr_en,
    input  logic [7:0]       wr_x,
    input  logic [7:0]       wr_y,
    input  logic             wr_val,
    output logic [CELLS-1:0] state,
    output logic             busy,
    output logic             gen_done,
    output logic [GEN_W-1:0] gen_count,
    output logic             wr_drop
);

    fsm_e              fsm_q;
    logic [CELLS-1:0]  state_q;
    logic [CELLS-1:0]  shadow_q;
    logic [ROW_W-1:0]  row_q;
    logic              pending_q;
    logic              pending_d;
    logic              freeze_q;
    logic              busy_q;
    logic              gen_done_q;
    logic [GEN_W-1:0]  gen_count_q;
    logic              wr_drop_q;
    logic              wr_in_range;
    logic [ROW_W-1:0]  row_up_idx;
    logic [ROW_W-1:0]  row_dn_idx;
    logic [GRID_W-1:0] row_up;
    logic [GRID_W-1:0] row_cur;
    logic [GRID_W-1:0] row_dn;
    logic [GRID_W-1:0] row_next;

    // Request merging: any unfrozen pulse queues one step; a rising freeze cancels the queued one
    always_comb begin
        wr_in_range = (wr_x < 8'(GRID_W)) && (wr_y < 8'(GRID_H));
        pending_d   = (pending_q && !(freeze && !freeze_q)) || (step_req && !freeze);
    end

    // Fetch the three state rows around the row being computed
    always_comb begin
        row_up_idx = (row_q == '0) ? ROW_W'(GRID_H - 1) : row_q - ROW_W'(1);
        row_dn_idx = (row_q == ROW_W'(GRID_H - 1)) ? '0 : row_q + ROW_W'(1);
        row_cur    = state_q[int'(row_q) * GRID_W +: GRID_W];
        row_up     = state_q[int'(row_up_idx) * GRID_W +: GRID_W];
        row_dn     = state_q[int'(row_dn_idx) * GRID_W +: GRID_W];
`ifndef LIFE_TORUS_EN
        if (row_q == '0) row_up = '0;
        if (row_q == ROW_W'(GRID_H - 1)) row_dn = '0;
`endif
    end

    life_row_calc u_row_calc (
        .row_up   (row_up),
        .row_cur  (row_cur),
        .row_dn   (row_dn),
        .row_next (row_next)
    );

    // Control FSM with the cell array, shadow buffer and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_q       <= ST_IDLE;
            state_q     <= '0;
            shadow_q    <= '0;
            row_q       <= '0;
            pending_q   <= 1'b0;
            freeze_q    <= 1'b0;
            busy_q      <= 1'b0;
            gen_done_q  <= 1'b0;
            gen_count_q <= '0;
            wr_drop_q   <= 1'b0;
        end else begin
            freeze_q   <= freeze;
            pending_q  <= pending_d;
            gen_done_q <= 1'b0;
            // Writes are only legal in IDLE and inside the grid; anything else is reported
            wr_drop_q  <= wr_en && (!wr_in_range || (fsm_q != ST_IDLE));
            case (fsm_q)
                ST_IDLE: begin
                    // A write takes the cycle; a queued step waits for a write-free cycle
                    if (wr_en) begin
                        if (wr_in_range) state_q[cell_idx(wr_x, wr_y)] <= wr_val;
                    end else if (pending_d) begin
                        pending_q <= 1'b0;
                        row_q     <= '0;
                        busy_q    <= 1'b1;
                        fsm_q     <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    shadow_q[int'(row_q) * GRID_W +: GRID_W] <= row_next;
                    if (row_q == ROW_W'(GRID_H - 1)) fsm_q <= ST_COMMIT;
                    else row_q <= row_q + ROW_W'(1);
                end
                ST_COMMIT: begin
                    state_q     <= shadow_q;
                    gen_count_q <= gen_count_q + GEN_W'(1);
                    gen_done_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    fsm_q       <= ST_IDLE;
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

    assign state     = state_q;
    assign busy      = busy_q;
    assign gen_done  = gen_done_q;
    assign gen_count = gen_count_q;
    assign wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_life_step_engine.sv
// Testbench for life_step_engine: whole-grid reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_life_step_engine;

    localparam int W = 64;
    localparam int H = 48;
    localparam int N = W * H;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         step_req = 1'b0;
    logic         freeze = 1'b0;
    logic         wr_en = 1'b0;
    logic [7:0]   wr_x = 8'd0;
    logic [7:0]   wr_y = 8'd0;
    logic         wr_val = 1'b0;
    logic [N-1:0] state;
    logic         busy;
    logic         gen_done;
    logic [15:0]  gen_count;
    logic         wr_drop;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    life_step_engine dut (
        .clk       (clk),
        .rst       (rst),
        .step_req  (step_req),
        .freeze    (freeze),
        .wr_en     (wr_en),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_val    (wr_val),
        .state     (state),
        .busy      (busy),
        .gen_done  (gen_done),
        .gen_count (gen_count),
        .wr_drop   (wr_drop)
    );

    // ---------------- reference model ----------------
    logic [N-1:0] m_state;
    logic [N-1:0] m_next;
    logic         m_busy;
    logic         m_done;
    logic         m_drop;
    logic         m_pend;
    logic         m_frz;
    int           m_cnt;
    logic [15:0]  m_gen;

    function automatic logic [N-1:0] life(input logic [N-1:0] s);
        logic [N-1:0] r;
        int n;
        int xx;
        int yy;
        r = '0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        xx = x + dx;
                        yy = y + dy;
                        if (!(dx == 0 && dy == 0)) begin
`ifdef LIFE_TORUS_EN
                            xx = (xx + W) % W;
                            yy = (yy + H) % H;
                            n += int'(s[yy*W+xx]);
`else
                            if (xx >= 0 && xx < W && yy >= 0 && yy < H) n += int'(s[yy*W+xx]);
`endif
                        end
                    end
                end
                r[y*W+x] = (n == 3) || (s[y*W+x] && n == 2);
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        logic inr;
        logic peff;
        if (!rst) begin
            m_state = '0; m_next = '0; m_busy = 0; m_done = 0; m_drop = 0;
            m_pend = 0; m_frz = 0; m_cnt = 0; m_gen = '0;
        end else begin
            inr    = (wr_x < 8'd64) && (wr_y < 8'd48);
            peff   = (m_pend && !(freeze && !m_frz)) || (step_req && !freeze);
            m_frz  = freeze;
            m_done = 0;
            m_drop = wr_en && (!inr || m_busy);
            m_pend = peff;
            if (!m_busy) begin
                if (wr_en) begin
                    if (inr) m_state[int'(wr_y)*W + int'(wr_x)] = wr_val;
                end else if (peff) begin
                    m_next = life(m_state);
                    m_busy = 1;
                    m_cnt  = 49;
                    m_pend = 0;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_state = m_next;
                    m_gen++;
                    m_done = 1;
                    m_busy = 0;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", nm, a, e, $time);
        end
    endtask

    task automatic cmp_state(input string nm, input logic [N-1:0] e);
        int first;
        checks++;
        if (state !== e) begin
            errors++;
            first = -1;
            for (int i = N - 1; i >= 0; i--) if (state[i] !== e[i]) first = i;
            $display("FAIL %s: actual pop=%0d required pop=%0d first diff cell x=%0d y=%0d at t=%0t",
                     nm, $countones(state), $countones(e), first % W, first / W, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("busy", 32'(busy), 32'(m_busy));
            cmp("gen_done", 32'(gen_done), 32'(m_done));
            cmp("gen_count", 32'(gen_count), 32'(m_gen));
            cmp("wr_drop", 32'(wr_drop), 32'(m_drop));
            cmp_state("state", m_state);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input int x, input int y, input logic v);
        wr_en = 1'b1; wr_x = 8'(x); wr_y = 8'(y); wr_val = v;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic step(output int c0);
        step_req = 1'b1;
        c0 = cyc;
        @(negedge clk);
        step_req = 1'b0;
    endtask

    task automatic wait_done(input string nm, output int c1);
        int n;
        n = 0;
        while (gen_done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        c1 = cyc;
        if (gen_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: actual=no gen_done required=gen_done within 300 cycles", nm);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [N-1:0] cells3(input int x0, input int y0, input int x1, input int y1,
                                            input int x2, input int y2);
        logic [N-1:0] e;
        e = '0;
        e[y0*W+x0] = 1'b1; e[y1*W+x1] = 1'b1; e[y2*W+x2] = 1'b1;
        return e;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        int c2;
        bit seen;
        logic [N-1:0] e;

        // Reset state
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        cmp("rst_pop", 32'($countones(state)), 0);
        cmp("rst_busy", 32'(busy), 0);
        cmp("rst_gen_count", 32'(gen_count), 0);
        cmp("rst_gen_done", 32'(gen_done), 0);
        rst = 1'b1;
        @(negedge clk);

        // Blinker: horizontal -> vertical, 50-cycle latency
        wr(10, 5, 1'b1); wr(11, 5, 1'b1); wr(12, 5, 1'b1);
        step(c0);
        wait_done("blinker", c1);
        cmp("blinker_latency", 32'(c1 - c0), 50);
        cmp_state("blinker_state", cells3(11, 4, 11, 5, 11, 6));
        cmp("blinker_gen", 32'(gen_count), 1);

        // Still life block, then freeze suppresses steps
        do_reset();
        wr(20, 20, 1'b1); wr(21, 20, 1'b1); wr(20, 21, 1'b1); wr(21, 21, 1'b1);
        e = '0;
        e[20*W+20] = 1'b1; e[20*W+21] = 1'b1; e[21*W+20] = 1'b1; e[21*W+21] = 1'b1;
        step(c0);
        wait_done("block", c1);
        cmp_state("block_state", e);
        freeze = 1'b1;
        @(negedge clk);
        step(c0);
        seen = 1'b0;
        repeat (60) begin
            if (busy === 1'b1 || gen_done === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        cmp("freeze_activity", 32'(seen), 0);
        cmp("freeze_gen", 32'(gen_count), 1);
        freeze = 1'b0;
        @(negedge clk);

        // Horizontal edge
        do_reset();
        wr(63, 10, 1'b1); wr(0, 10, 1'b1); wr(1, 10, 1'b1);
        step(c0);
        wait_done("edge", c1);
`ifdef LIFE_TORUS_EN
        cmp_state("edge_state", cells3(0, 9, 0, 10, 0, 11));
`else
        cmp_state("edge_state", '0);
`endif

        // Write while busy is dropped; out-of-range writes are dropped
        do_reset();
        wr(5, 5, 1'b1);
        step(c0);
        repeat (9) @(negedge clk);
        wr(30, 30, 1'b1);
        cmp("busy_wr_drop", 32'(wr_drop), 1);
        wait_done("busywr", c1);
        cmp("busy_wr_cell", 32'(state[30*W+30]), 0);
        cmp("busy_wr_pop", 32'($countones(state)), 0);
        wr(64, 0, 1'b1);
        cmp("oor_x_drop", 32'(wr_drop), 1);
        wr(3, 48, 1'b1);
        cmp("oor_y_drop", 32'(wr_drop), 1);
        cmp("oor_pop", 32'($countones(state)), 0);

        // Same-cycle write and step, then a queued second generation
        do_reset();
        wr(10, 5, 1'b1); wr(11, 5, 1'b1);
        wr_en = 1'b1; wr_x = 8'd12; wr_y = 8'd5; wr_val = 1'b1; step_req = 1'b1;
        c0 = cyc;
        @(negedge clk);
        wr_en = 1'b0; step_req = 1'b0;
        cmp("ws_write", 32'(state[5*W+12]), 1);
        cmp("ws_busy_t1", 32'(busy), 0);
        @(negedge clk);
        cmp("ws_busy_t2", 32'(busy), 1);
        repeat (5) @(negedge clk);
        step(c2);
        wait_done("ws1", c1);
        cmp("ws_latency", 32'(c1 - c0), 51);
        @(negedge clk);
        wait_done("ws2", c2);
        cmp("queued_gap", 32'(c2 - c1), 50);
        cmp("queued_gen", 32'(gen_count), 2);
        cmp_state("queued_state", cells3(10, 5, 11, 5, 12, 5));

        // Reset in the middle of COMPUTE
        do_reset();
        wr(10, 5, 1'b1); wr(11, 5, 1'b1); wr(12, 5, 1'b1);
        step(c0);
        wait_done("pre_rst", c1);
        @(negedge clk);
        step(c0);
        repeat (30) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cmp("midrst_pop", 32'($countones(state)), 0);
        cmp("midrst_busy", 32'(busy), 0);
        cmp("midrst_gen", 32'(gen_count), 0);
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (gen_done === 1'b1) seen = 1'b1;
        end
        cmp("midrst_no_done", 32'(seen), 0);

        // Random fill, then random mixed traffic
        do_reset();
        for (int i = 0; i < 700; i++) begin
            wr($urandom_range(0, 66), $urandom_range(0, 49), ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 3500; i++) begin
            step_req = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 59) == 0) freeze = ~freeze;
            wr_en  = ($urandom_range(0, 5) == 0);
            wr_x   = 8'($urandom_range(0, 68));
            wr_y   = 8'($urandom_range(0, 50));
            wr_val = ($urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        step_req = 1'b0; wr_en = 1'b0; freeze = 1'b0;
        repeat (120) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
